hazard_unit: RTL and testbench
==============================

# hazard_unit

Hazard detection and forwarding unit for the five-stage pipelined RISC-V core. It consumes the stage-tagged control signals the pipelined controller emits (ResultSrcE, PCSrcE, RegWriteM, RegWriteW) together with decode-stage register addresses. It tracks those addresses through its own E/M/W index pipeline and drives the stall, flush and forwarding-select signals back into the datapath and controller pipeline registers. It also keeps two event counters for performance inspection.

## Interface

- REG_ADDR_W, 5, width of a register index
- CNT_W, 32, width of each event counter

- clk  in  1  pipeline clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset (0 = reset, 1 = run)
- Rs1D  in  REG_ADDR_W  source register 1 of the instruction in DECODE
- Rs2D  in  REG_ADDR_W  source register 2 of the instruction in DECODE
- RdD  in  REG_ADDR_W  destination register of the instruction in DECODE
- ResultSrcE  in  2  result select of the EXECUTE instruction; 2'b01 = load
- PCSrcE  in  1  taken branch or jump resolved in EXECUTE
- RegWriteM  in  1  MEMORY-stage instruction writes the register file
- RegWriteW  in  1  WRITEBACK-stage instruction writes the register file
- StallF  out  1  hold PC register
- StallD  out  1  hold FETCH/DECODE pipeline register
- FlushD  out  1  clear FETCH/DECODE pipeline register
- FlushE  out  1  clear DECODE/EXECUTE pipeline registers (datapath and controller)
- ForwardAE  out  2  ALU operand A select: 00 register file, 01 ResultW, 10 ALUResultM
- ForwardBE  out  2  ALU operand B select, same encoding
- LoadUseStalls  out  CNT_W  count of cycles with an effective load-use stall
- BranchFlushes  out  CNT_W  count of cycles with PCSrcE asserted

## Operation

- Internal index pipeline: Rs1E, Rs2E, RdE (D→E), RdM (E→M), RdW (M→W). All registers are REG_ADDR_W wide.
- D→E registers: on a clock edge with FlushE=1, load 0; otherwise capture Rs1D/Rs2D/RdD. StallD does not hold them, because a stall inserts a bubble through FlushE.
- E→M and M→W registers capture unconditionally each edge.
- Load-use detect: lwStall = (ResultSrcE==2'b01) & (RdE!=0) & ((RdE==Rs1D) | (RdE==Rs2D)).
- Control resolution: PCSrcE has priority, because the DECODE instruction is discarded anyway.
  - effStall = lwStall & ~PCSrcE.
  - StallF = StallD = effStall.
  - FlushD = PCSrcE.
  - FlushE = effStall | PCSrcE.
- Forwarding, operand A (B identical with Rs2E):
  - 10 if RegWriteM & (RdM==Rs1E) & (Rs1E!=0).
  - Else 01 if RegWriteW & (RdW==Rs1E) & (Rs1E!=0).
  - Else 00.
  - MEMORY has priority over WRITEBACK.
- Register x0 never triggers a stall or a forward.
- Counters:
  - LoadUseStalls increments by 1 on each edge where effStall=1.
  - BranchFlushes increments by 1 on each edge where PCSrcE=1.
  - Both wrap modulo 2^CNT_W (all-ones → 0).
- Reset (resetn=0, asynchronous):
  - All index registers and both counters go to 0.
  - Consequently ForwardAE=ForwardBE=00 and StallF=StallD=0.
  - FlushE and FlushD follow PCSrcE only.
  - Reset mid-stall drops the stall immediately, without waiting for a clock edge.

## Timing

- Stall, flush and forward outputs are combinational from current inputs and registered indices. There are no registered outputs other than the counters.
- Forward selects are valid in the same cycle the consuming instruction is in EXECUTE.
- A load-use stall lasts exactly 1 cycle. The next edge flushes RdE to 0, so lwStall deasserts and the dependent instruction enters EXECUTE one cycle later, with ForwardxE=01 from WRITEBACK.
- A taken branch produces a single flush cycle: FlushD and FlushE are high for exactly the cycles PCSrcE is high.
- Counter values are visible the cycle after the counted event.

## Test plan

- Reset: drive resetn=0 with Rs1D=RdD=5 and ResultSrcE=01. Required: Stall*=0, Forward*=00, counters=0. Then release resetn.
- Load-use: with a load to x5 in E (RdE=5, ResultSrcE=01) and Rs2D=5. Required: StallF=StallD=FlushE=1 for 1 cycle; the next cycle has no stall; after 2 more edges ForwardBE=01; LoadUseStalls=1.
- M/W forwarding priority: RdM=RdW=7, RegWriteM=RegWriteW=1, Rs1E=7 → ForwardAE=10. Then drop RegWriteM → ForwardAE=01. Then drop RegWriteW → ForwardAE=00.
- x0: RdM=0, RegWriteM=1, Rs1E=Rs2E=0 → ForwardAE=ForwardBE=00. A load with RdE=0 and Rs1D=0 → no stall.
- Branch and simultaneous events: PCSrcE=1 together with a load-use condition. Required: FlushD=FlushE=1, StallF=StallD=0, BranchFlushes +1, LoadUseStalls unchanged.
- Counter wrap: with CNT_W=4, hold PCSrcE=1 for 17 edges → BranchFlushes=1.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding unit for the five-stage RISC-V pipeline.
// Tracks E/M/W register indices and emits stall, flush, forward selects and two event counters.
module hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic [1:0]            ResultSrcE,
    input  logic                  PCSrcE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic [CNT_W-1:0]      LoadUseStalls,
    output logic [CNT_W-1:0]      BranchFlushes
);

    localparam logic [REG_ADDR_W-1:0] REG_X0   = {REG_ADDR_W{1'b0}};
    localparam logic [1:0]            RES_LOAD = 2'b01;
    localparam logic [1:0]            FWD_RF   = 2'b00;
    localparam logic [1:0]            FWD_WB   = 2'b01;
    localparam logic [1:0]            FWD_MEM  = 2'b10;
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [REG_ADDR_W-1:0] rs1_e_q, rs1_e_d;
    logic [REG_ADDR_W-1:0] rs2_e_q, rs2_e_d;
    logic [REG_ADDR_W-1:0] rd_e_q,  rd_e_d;
    logic [REG_ADDR_W-1:0] rd_m_q;
    logic [REG_ADDR_W-1:0] rd_w_q;
    logic [CNT_W-1:0]      lus_cnt_q, lus_cnt_d;
    logic [CNT_W-1:0]      bfl_cnt_q, bfl_cnt_d;
    logic                  lw_stall_s;
    logic                  eff_stall_s;
    logic                  flush_e_s;

    // MEMORY result is newer than WRITEBACK, so it wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [REG_ADDR_W-1:0] rs_e,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  we_m,
        input logic                  we_w
    );
        logic [1:0] sel;
        if (rs_e == REG_X0) begin
            sel = FWD_RF;
        end else if (we_m && (rd_m == rs_e)) begin
            sel = FWD_MEM;
        end else if (we_w && (rd_w == rs_e)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Load-use detection and stall/flush resolution; a taken branch overrides the stall.
    always_comb begin
        lw_stall_s  = 1'b0;
        eff_stall_s = 1'b0;
        flush_e_s   = 1'b0;
        if ((ResultSrcE == RES_LOAD) && (rd_e_q != REG_X0) &&
            ((rd_e_q == Rs1D) || (rd_e_q == Rs2D))) begin
            lw_stall_s = 1'b1;
        end else begin
            lw_stall_s = 1'b0;
        end
        eff_stall_s = lw_stall_s & ~PCSrcE;
        flush_e_s   = eff_stall_s | PCSrcE;
    end

    // Drive control outputs.
    always_comb begin
        StallF    = eff_stall_s;
        StallD    = eff_stall_s;
        FlushD    = PCSrcE;
        FlushE    = flush_e_s;
        ForwardAE = fwd_select(rs1_e_q, rd_m_q, rd_w_q, RegWriteM, RegWriteW);
        ForwardBE = fwd_select(rs2_e_q, rd_m_q, rd_w_q, RegWriteM, RegWriteW);
    end

    // Next-state for the D->E indices (bubble on flush) and the event counters.
    always_comb begin
        rs1_e_d   = Rs1D;
        rs2_e_d   = Rs2D;
        rd_e_d    = RdD;
        lus_cnt_d = lus_cnt_q;
        bfl_cnt_d = bfl_cnt_q;
        if (flush_e_s) begin
            rs1_e_d = REG_X0;
            rs2_e_d = REG_X0;
            rd_e_d  = REG_X0;
        end else begin
            rs1_e_d = Rs1D;
            rs2_e_d = Rs2D;
            rd_e_d  = RdD;
        end
        if (eff_stall_s) begin
            lus_cnt_d = lus_cnt_q + CNT_ONE;
        end else begin
            lus_cnt_d = lus_cnt_q;
        end
        if (PCSrcE) begin
            bfl_cnt_d = bfl_cnt_q + CNT_ONE;
        end else begin
            bfl_cnt_d = bfl_cnt_q;
        end
    end

    // Index pipeline registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rs1_e_q <= REG_X0;
            rs2_e_q <= REG_X0;
            rd_e_q  <= REG_X0;
            rd_m_q  <= REG_X0;
            rd_w_q  <= REG_X0;
        end else begin
            rs1_e_q <= rs1_e_d;
            rs2_e_q <= rs2_e_d;
            rd_e_q  <= rd_e_d;
            rd_m_q  <= rd_e_q;
            rd_w_q  <= rd_m_q;
        end
    end

    // Event counters; they wrap naturally at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lus_cnt_q <= {CNT_W{1'b0}};
            bfl_cnt_q <= {CNT_W{1'b0}};
        end else begin
            lus_cnt_q <= lus_cnt_d;
            bfl_cnt_q <= bfl_cnt_d;
        end
    end

    assign LoadUseStalls = lus_cnt_q;
    assign BranchFlushes = bfl_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic
// compared against an instruction-level pipeline model.
module tb_hazard_unit;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int CMOD = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic [RW-1:0] Rs1D, Rs2D, RdD;
    logic [1:0]    ResultSrcE;
    logic          PCSrcE, RegWriteM, RegWriteW;
    logic          StallF, StallD, FlushD, FlushE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] LoadUseStalls, BranchFlushes;

    hazard_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .LoadUseStalls(LoadUseStalls), .BranchFlushes(BranchFlushes)
    );

    always #5 clk = ~clk;

    typedef struct { int rs1; int rs2; int rd; } instr_t;
    instr_t ex, mem, wb;
    int m_lus, m_bf;
    int errors = 0;
    int checks = 0;
    int b0, l0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_stall();
        bit hit;
        hit = (ResultSrcE == 2'b01) && (ex.rd != 0) &&
              ((ex.rd == int'(Rs1D)) || (ex.rd == int'(Rs2D)));
        return (hit && !PCSrcE) ? 1 : 0;
    endfunction

    function automatic int exp_fwd(input int rs);
        if (rs == 0) return 0;
        if (RegWriteM && (mem.rd == rs)) return 2;
        if (RegWriteW && (wb.rd == rs)) return 1;
        return 0;
    endfunction

    task automatic model_clear();
        ex = '{0, 0, 0}; mem = '{0, 0, 0}; wb = '{0, 0, 0};
        m_lus = 0; m_bf = 0;
    endtask

    task automatic check_comb(input string tag);
        int st;
        st = exp_stall();
        chk({tag, ".StallF"}, 32'(StallF), st);
        chk({tag, ".StallD"}, 32'(StallD), st);
        chk({tag, ".FlushD"}, 32'(FlushD), 32'(PCSrcE));
        chk({tag, ".FlushE"}, 32'(FlushE), (st != 0 || PCSrcE) ? 1 : 0);
        chk({tag, ".FwdA"}, 32'(ForwardAE), exp_fwd(ex.rs1));
        chk({tag, ".FwdB"}, 32'(ForwardBE), exp_fwd(ex.rs2));
    endtask

    task automatic step();
        int st;
        @(posedge clk);
        if (!resetn) begin
            model_clear();
        end else begin
            st = exp_stall();
            if (st != 0) m_lus = (m_lus + 1) % CMOD;
            if (PCSrcE) m_bf = (m_bf + 1) % CMOD;
            wb = mem;
            mem = ex;
            if (st != 0 || PCSrcE) ex = '{0, 0, 0};
            else ex = '{int'(Rs1D), int'(Rs2D), int'(RdD)};
        end
        #1;
        chk("cnt.LoadUse", 32'(LoadUseStalls), m_lus);
        chk("cnt.Branch", 32'(BranchFlushes), m_bf);
    endtask

    task automatic drive(input int rs1, input int rs2, input int rd, input int rsrc,
                         input bit pcs, input bit wm, input bit ww);
        @(negedge clk);
        Rs1D = RW'(rs1); Rs2D = RW'(rs2); RdD = RW'(rd);
        ResultSrcE = 2'(rsrc); PCSrcE = pcs; RegWriteM = wm; RegWriteW = ww;
        #1;
        check_comb("drv");
    endtask

    initial begin
        resetn = 1'b0;
        Rs1D = 5'd5; Rs2D = 5'd0; RdD = 5'd5; ResultSrcE = 2'b01;
        PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        model_clear();
        #2;
        check_comb("rst");
        chk("rst.StallF", 32'(StallF), 0);
        chk("rst.FwdA", 32'(ForwardAE), 0);
        chk("rst.LoadUse", 32'(LoadUseStalls), 0);
        chk("rst.Branch", 32'(BranchFlushes), 0);
        step();
        step();
        @(negedge clk) resetn = 1'b1;

        // load-use: load to x5 enters E, dependent reads x5 via rs2
        drive(1, 2, 5, 0, 0, 0, 0); step();
        drive(0, 5, 6, 1, 0, 0, 0);
        chk("lu.StallF", 32'(StallF), 1);
        chk("lu.FlushE", 32'(FlushE), 1);
        step();
        chk("lu.count", 32'(LoadUseStalls), 1);
        drive(0, 5, 6, 0, 0, 0, 0);
        chk("lu.released", 32'(StallF), 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("lu.FwdB_wb", 32'(ForwardBE), 1);
        step();

        // M/W priority on operand A
        drive(0, 0, 7, 0, 0, 0, 0); step();
        drive(0, 0, 7, 0, 0, 0, 0); step();
        drive(7, 0, 0, 0, 0, 0, 0); step();
        @(negedge clk);
        Rs1D = 5'd0; RegWriteM = 1'b1; RegWriteW = 1'b1; #1;
        check_comb("mw1"); chk("mw.mem", 32'(ForwardAE), 2);
        RegWriteM = 1'b0; #1;
        check_comb("mw2"); chk("mw.wb", 32'(ForwardAE), 1);
        RegWriteW = 1'b0; #1;
        check_comb("mw3"); chk("mw.none", 32'(ForwardAE), 0);
        step();

        // x0 never forwards nor stalls
        drive(0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0); step();
        @(negedge clk);
        RegWriteM = 1'b1; RegWriteW = 1'b1; #1;
        chk("x0.FwdA", 32'(ForwardAE), 0);
        chk("x0.FwdB", 32'(ForwardBE), 0);
        ResultSrcE = 2'b01; #1;
        chk("x0.nostall", 32'(StallF), 0);
        check_comb("x0");
        step();

        // branch together with a load-use condition
        drive(0, 0, 5, 0, 0, 0, 0); step();
        drive(5, 0, 0, 1, 1, 0, 0);
        chk("br.FlushD", 32'(FlushD), 1);
        chk("br.FlushE", 32'(FlushE), 1);
        chk("br.StallF", 32'(StallF), 0);
        chk("br.StallD", 32'(StallD), 0);
        b0 = m_bf; l0 = m_lus;
        step();
        chk("br.count", 32'(BranchFlushes), (b0 + 1) % CMOD);
        chk("br.lus_same", 32'(LoadUseStalls), l0);

        // asynchronous reset mid-stall
        drive(0, 0, 5, 0, 0, 0, 0); step();
        drive(5, 0, 0, 1, 0, 0, 0);
        chk("ar.stall_on", 32'(StallF), 1);
        #1 resetn = 1'b0; model_clear();
        #1;
        chk("ar.StallF", 32'(StallF), 0);
        chk("ar.StallD", 32'(StallD), 0);
        chk("ar.LoadUse", 32'(LoadUseStalls), 0);
        check_comb("ar");
        step();
        @(negedge clk) resetn = 1'b1;

        // counter wrap: 17 branch edges on a 4-bit counter
        drive(0, 0, 0, 0, 1, 0, 0);
        repeat (17) step();
        chk("wrap.Branch", 32'(BranchFlushes), 1);

        // randomized traffic
        repeat (400) begin
            @(negedge clk);
            Rs1D = RW'($urandom_range(0, 3));
            Rs2D = RW'($urandom_range(0, 3));
            RdD = RW'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE = ($urandom_range(0, 7) == 0);
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            resetn = ($urandom_range(0, 99) != 0);
            if (!resetn) model_clear();
            #1;
            check_comb("rnd");
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
